// File: rtl/commu_tp_pkg.sv
// Shared constants for the commu_m test-pattern source: mode codes, config layout,
// PRBS7 seed/taps and the fixed-pattern byte list.
package commu_tp_pkg;

    typedef enum logic [2:0] {
        TP_FIX   = 3'd0,
        TP_INC   = 3'd1,
        TP_DEC   = 3'd2,
        TP_WALK  = 3'd3,
        TP_PRBS7 = 3'd4
    } tp_mode_e;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       en;
        logic [2:0] mode;
    } tp_cfg_t;

    localparam int unsigned PRBS7_W      = 7;
    localparam logic [PRBS7_W-1:0] PRBS7_SEED = 7'h7F;
    localparam int unsigned PRBS7_TAP_HI = 6;
    localparam int unsigned PRBS7_TAP_LO = 5;

    localparam int unsigned FIX_N = 4;
    // Index 0 is the first word after a restart.
    localparam logic [FIX_N-1:0][7:0] FIX_BYTES = {8'hA5, 8'h5A, 8'hAA, 8'h55};

endpackage

// File: rtl/commu_tp_lfsr.sv
// Combinational DW-step PRBS7 advance; the caller owns the state register.
module commu_tp_lfsr
    import commu_tp_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [PRBS7_W-1:0] i_state,
    output logic [DW-1:0]      o_word,
    output logic [PRBS7_W-1:0] o_next
);

    logic [PRBS7_W-1:0] w_s;

    // Serial bit is the MSB of the state; word is packed MSB first.
    always_comb begin
        w_s    = i_state;
        o_word = '0;
        for (int i = 0; i < DW; i++) begin
            o_word[DW-1-i] = w_s[PRBS7_W-1];
            w_s = {w_s[PRBS7_W-2:0], w_s[PRBS7_TAP_HI] ^ w_s[PRBS7_TAP_LO]};
        end
        o_next = w_s;
    end

endmodule

// File: rtl/commu_tp_gen.sv
// Parametrised show-ahead test-pattern source with optional framing, word and
// frame counters. Any change of cfg_tp restarts the whole generator.
module commu_tp_gen
    import commu_tp_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             tp_rd,
    output logic [DW-1:0]    tp_q,
    output logic             tp_sof,
    output logic             tp_eof,
    output logic [31:0]      tp_cnt,
    output logic [LEN_W-1:0] tp_frm_cnt,
    input  logic [7:0]       cfg_tp,
    input  logic [LEN_W-1:0] cfg_len
);

    tp_cfg_t              r_cfg;
    tp_cfg_t              w_cfg_new;
    logic [DW-1:0]        r_word;
    logic [1:0]           r_fix;
    logic [PRBS7_W-1:0]   r_lfsr;
    logic [LEN_W-1:0]     r_idx;
    logic [31:0]          r_cnt;
    logic [LEN_W-1:0]     r_frm;

    logic                 w_restart;
    logic                 w_adv;
    logic                 w_eof;
    logic [DW-1:0]        w_init_word;
    logic [DW-1:0]        w_prbs_word;
    logic [PRBS7_W-1:0]   w_prbs_next;

    assign w_cfg_new = tp_cfg_t'(cfg_tp);
    assign w_restart = (w_cfg_new != r_cfg);
    assign w_adv     = r_cfg.en && tp_rd && !w_restart;
    assign w_eof     = r_cfg.en && (cfg_len != '0) && (r_idx >= LEN_W'(cfg_len - LEN_W'(1)));

    commu_tp_lfsr #(
        .DW (DW)
    ) u_lfsr (
        .i_state (r_lfsr),
        .o_word  (w_prbs_word),
        .o_next  (w_prbs_next)
    );

    // Starting word for the arithmetic/walking modes, taken from the incoming config.
    always_comb begin
        w_init_word = '0;
        case (w_cfg_new.mode)
            TP_DEC:  w_init_word = '1;
            TP_WALK: w_init_word = DW'(1);
            default: w_init_word = '0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg  <= '0;
            r_word <= '0;
            r_fix  <= '0;
            r_lfsr <= PRBS7_SEED;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_frm  <= '0;
        end else if (w_restart) begin
            r_cfg  <= w_cfg_new;
            r_word <= w_init_word;
            r_fix  <= '0;
            r_lfsr <= PRBS7_SEED;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_frm  <= '0;
        end else if (w_adv) begin
            case (r_cfg.mode)
                TP_FIX:   r_fix  <= r_fix + 2'd1;
                TP_INC:   r_word <= r_word + DW'(1);
                TP_DEC:   r_word <= r_word - DW'(1);
                TP_WALK:  r_word <= {r_word[DW-2:0], r_word[DW-1]};
                TP_PRBS7: r_lfsr <= w_prbs_next;
                default:  r_word <= r_word;
            endcase

            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 32'd1;
            end

            // Unframed operation parks idx at 1 so only the first word carries sof.
            if (w_eof) begin
                r_idx <= '0;
                r_frm <= r_frm + LEN_W'(1);
            end else if (cfg_len == '0) begin
                r_idx <= LEN_W'(1);
            end else begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    always_comb begin
        tp_q = '0;
        if (r_cfg.en) begin
            case (r_cfg.mode)
                TP_FIX:   tp_q = {(DW/8){FIX_BYTES[r_fix]}};
                TP_INC:   tp_q = r_word;
                TP_DEC:   tp_q = r_word;
                TP_WALK:  tp_q = r_word;
                TP_PRBS7: tp_q = w_prbs_word;
                default:  tp_q = '0;
            endcase
        end
    end

    assign tp_sof     = r_cfg.en && (r_idx == '0);
    assign tp_eof     = w_eof;
    assign tp_cnt     = r_cnt;
    assign tp_frm_cnt = r_frm;

endmodule
